// File: rtl/adc_dc_pkg.sv
// Shared constants and helpers for the multi-channel DC-offset remover.
// ADC_DC_SAT_EN selects saturation instead of wrap when reducing the correction difference.
package adc_dc_pkg;

  localparam int unsigned DefW       = 16;
  localparam int unsigned DefAvgLog2 = 10;

  // Accumulator width: one full window of W-bit samples never overflows.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned avg_log2);
    return w + avg_log2;
  endfunction

  // Reduce a sign-extended difference to a w-bit two's-complement value (w <= 31).
  function automatic int signed sat_w(input int signed diff, input int unsigned w);
    int signed hi;
    int signed lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
`ifdef ADC_DC_SAT_EN
    if (diff > hi) begin
      return hi;
    end
    if (diff < lo) begin
      return lo;
    end
    return diff;
`else
    // Keep the low w bits and sign-extend them; hi/lo only bound the result here.
    if (hi < lo) begin
      return 32'sd0;
    end
    return (diff <<< (32 - w)) >>> (32 - w);
`endif
  endfunction

endpackage

// File: rtl/adc_dc_remover_if.sv
// Sample-stream bundle for adc_dc_remover: input samples and controls, corrected samples and means.
// The master drives samples and controls; the slave (the remover) drives the results.
interface adc_dc_remover_if
  import adc_dc_pkg::*;
#(
  parameter int unsigned NCH = 16,
  parameter int unsigned W   = DefW
);

  logic              DIN_VALID;
  logic [NCH*W-1:0]  DIN;
  logic [NCH-1:0]    BYPASS;
  logic              MEAN_HOLD;
  logic              DOUT_VALID;
  logic [NCH*W-1:0]  DOUT;
  logic [NCH*W-1:0]  MEAN_OUT;
  logic              MEAN_UPDATE;

  modport master (
    output DIN_VALID,
    output DIN,
    output BYPASS,
    output MEAN_HOLD,
    input  DOUT_VALID,
    input  DOUT,
    input  MEAN_OUT,
    input  MEAN_UPDATE
  );

  modport slave (
    input  DIN_VALID,
    input  DIN,
    input  BYPASS,
    input  MEAN_HOLD,
    output DOUT_VALID,
    output DOUT,
    output MEAN_OUT,
    output MEAN_UPDATE
  );

endinterface

// File: rtl/adc_dc_chan.sv
// One channel of the DC remover: window accumulator, mean register and two-stage correction pipe.
// Output reduction follows ADC_DC_SAT_EN (saturate) or its absence (wrap), via sat_w.
module adc_dc_chan
  import adc_dc_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned AVG_LOG2 = DefAvgLog2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din_valid,
  input  logic                s1_valid,
  input  logic                win_last,
  input  logic                mean_hold,
  input  logic                bypass,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout,
  output logic signed [W-1:0] mean
);

  localparam int unsigned AccW = acc_width(W, AVG_LOG2);
  localparam int unsigned DiffW = W + 1;

  logic signed [AccW-1:0]  acc_q, acc_d, sum;
  logic signed [W-1:0]     mean_q, mean_d;
  logic signed [W-1:0]     s1_data_q, s1_mean_q;
  logic                    s1_byp_q;
  logic signed [W-1:0]     dout_q, dout_d;
  logic signed [DiffW-1:0] diff;

  always_comb begin
    sum    = acc_q + AccW'(din);
    acc_d  = acc_q;
    mean_d = mean_q;
    if (din_valid) begin
      if (win_last) begin
        acc_d = '0;
        // Arithmetic shift floors the mean toward minus infinity.
        if (!mean_hold) begin
          mean_d = W'(sum >>> AVG_LOG2);
        end
      end else begin
        acc_d = sum;
      end
    end
  end

  always_comb begin
    diff   = DiffW'(s1_data_q) - DiffW'(s1_mean_q);
    dout_d = s1_byp_q ? s1_data_q : W'(sat_w(32'(diff), W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mean_q    <= '0;
      s1_data_q <= '0;
      s1_mean_q <= '0;
      s1_byp_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      acc_q  <= acc_d;
      mean_q <= mean_d;
      if (din_valid) begin
        s1_data_q <= din;
        s1_mean_q <= mean_q;
        s1_byp_q  <= bypass;
      end
      if (s1_valid) begin
        dout_q <= dout_d;
      end
    end
  end

  assign dout = dout_q;
  assign mean = mean_q;

endmodule

// File: rtl/adc_dc_remover.sv
// Multi-channel DC-offset remover: shared window counter, per-channel mean subtraction.
// Build option ADC_DC_SAT_EN saturates corrected samples instead of wrapping; W must be <= 31.
module adc_dc_remover
  import adc_dc_pkg::*;
#(
  parameter int unsigned NCH      = 16,
  parameter int unsigned W        = DefW,
  parameter int unsigned AVG_LOG2 = DefAvgLog2
) (
  input logic              CLK_20M,
  input logic              RESET_n,
  adc_dc_remover_if.slave  bus
);

  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                win_last;
  logic                s1_valid_q;
  logic                dout_valid_q;
  logic                mean_update_q, mean_update_d;
  logic [NCH*W-1:0]    dout_all;
  logic [NCH*W-1:0]    mean_all;

  // The counter wraps naturally at 2^AVG_LOG2; the all-ones value marks the window end.
  always_comb begin
    win_last      = &cnt_q;
    cnt_d         = bus.DIN_VALID ? cnt_q + AVG_LOG2'(1) : cnt_q;
    mean_update_d = bus.DIN_VALID & win_last & ~bus.MEAN_HOLD;
  end

  always_ff @(posedge CLK_20M or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q         <= '0;
      s1_valid_q    <= 1'b0;
      dout_valid_q  <= 1'b0;
      mean_update_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      s1_valid_q    <= bus.DIN_VALID;
      dout_valid_q  <= s1_valid_q;
      mean_update_q <= mean_update_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    adc_dc_chan #(
      .W        (W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_chan (
      .clk       (CLK_20M),
      .rst_n     (RESET_n),
      .din_valid (bus.DIN_VALID),
      .s1_valid  (s1_valid_q),
      .win_last  (win_last),
      .mean_hold (bus.MEAN_HOLD),
      .bypass    (bus.BYPASS[k]),
      .din       (bus.DIN[k*W +: W]),
      .dout      (dout_all[k*W +: W]),
      .mean      (mean_all[k*W +: W])
    );
  end

  assign bus.DOUT        = dout_all;
  assign bus.MEAN_OUT    = mean_all;
  assign bus.DOUT_VALID  = dout_valid_q;
  assign bus.MEAN_UPDATE = mean_update_q;

endmodule

// File: tb/tb_adc_dc_remover.sv
// Bench for adc_dc_remover (NCH=4, W=16, AVG_LOG2=2): directed scenarios, then random traffic,
// all checked every cycle against a window/mean model, plus a few hand-computed values.
module tb_adc_dc_remover;

  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int AVG  = 2;
  localparam int WIN  = 4;
  localparam int NCYC = 2048;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  adc_dc_remover_if #(.NCH(NCH), .W(W)) bus ();

  adc_dc_remover #(
    .NCH      (NCH),
    .W        (W),
    .AVG_LOG2 (AVG)
  ) dut (
    .CLK_20M (clk),
    .RESET_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: running window sums, sample count in window, current means.
  int m_sum  [NCH];
  int m_mean [NCH];
  int m_wcnt;
  int din_v  [NCH];

  // Expectations indexed by the cycle in which the DUT output must show them.
  bit                 chk_en    [NCYC];
  bit                 exp_valid [NCYC];
  bit                 exp_mu    [NCYC];
  logic [NCH*W-1:0]   exp_dout  [NCYC];
  logic [NCH*W-1:0]   exp_mean  [NCYC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [15:0] reduce(input int x);
`ifdef ADC_DC_SAT_EN
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
`endif
    return 16'(x);
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] ch(input logic [NCH*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic model_clear();
    m_wcnt = 0;
    for (int k = 0; k < NCH; k++) begin
      m_sum[k]  = 0;
      m_mean[k] = 0;
    end
    for (int i = 0; i < NCYC; i++) begin
      chk_en[i]    = 1'b0;
      exp_valid[i] = 1'b0;
    end
  endtask

  // Present one cycle of inputs, predict its effects, then advance to just after the edge.
  task automatic drive_cycle(input bit v, input logic [NCH-1:0] byp, input bit hold);
    int          idx;
    logic [15:0] e;
    idx = cyc;
    bus.DIN_VALID = v;
    bus.BYPASS    = byp;
    bus.MEAN_HOLD = hold;
    for (int k = 0; k < NCH; k++) bus.DIN[k*W +: W] = 16'(din_v[k]);
    if (idx + 2 < NCYC) begin
      chk_en[idx+1]    = 1'b1;
      exp_mu[idx+1]    = 1'b0;
      exp_valid[idx+2] = v;
      if (v) begin
        for (int k = 0; k < NCH; k++) begin
          e = byp[k] ? 16'(din_v[k]) : reduce(din_v[k] - m_mean[k]);
          exp_dout[idx+2][k*W +: W] = e;
          m_sum[k] += din_v[k];
        end
        m_wcnt++;
        if (m_wcnt == WIN) begin
          m_wcnt = 0;
          if (!hold) exp_mu[idx+1] = 1'b1;
          for (int k = 0; k < NCH; k++) begin
            if (!hold) m_mean[k] = floor_div(m_sum[k], WIN);
            m_sum[k] = 0;
          end
        end
      end
      for (int k = 0; k < NCH; k++) exp_mean[idx+1][k*W +: W] = 16'(m_mean[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int a, input int b, input int c, input int d);
    din_v[0] = a;
    din_v[1] = b;
    din_v[2] = c;
    din_v[3] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.DIN_VALID = 1'b0;
    bus.MEAN_HOLD = 1'b0;
    bus.BYPASS    = '0;
    model_clear();
    #1;
    check("reset_dout", 64'(bus.DOUT), 64'd0);
    check("reset_dout_valid", 64'(bus.DOUT_VALID), 64'd0);
    check("reset_mean_out", 64'(bus.MEAN_OUT), 64'd0);
    check("reset_mean_update", 64'(bus.MEAN_UPDATE), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cyc >= 0 && cyc < NCYC && chk_en[cyc]) begin
      check("dout_valid", 64'(bus.DOUT_VALID), 64'(exp_valid[cyc]));
      check("mean_update", 64'(bus.MEAN_UPDATE), 64'(exp_mu[cyc]));
      check("mean_out", 64'(bus.MEAN_OUT), 64'(exp_mean[cyc]));
      if (exp_valid[cyc]) check("dout", 64'(bus.DOUT), 64'(exp_dout[cyc]));
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.DIN = '0;
    set_din(0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Window 1: DC, negative floor, most-negative window, bypassed ch3.
    set_din(100, -1, -32768, 200);
    drive_cycle(1'b1, 4'b1000, 1'b0);
    drive_cycle(1'b1, 4'b1000, 1'b0);
    drive_cycle(1'b1, 4'b1000, 1'b0);
    set_din(100, 0, -32768, 200);
    drive_cycle(1'b1, 4'b1000, 1'b0);
    check("lit_mean_update_w1", 64'(bus.MEAN_UPDATE), 64'd1);
    check("lit_mean_ch0", 64'(ch(bus.MEAN_OUT, 0)), 64'd100);
    check("lit_mean_ch1", 64'(ch(bus.MEAN_OUT, 1)), 64'hffff);
    check("lit_mean_ch2", 64'(ch(bus.MEAN_OUT, 2)), 64'h8000);
    check("lit_mean_ch3", 64'(ch(bus.MEAN_OUT, 3)), 64'd200);
    set_din(100, 5, 32767, 200);
    drive_cycle(1'b1, 4'b1000, 1'b0);
    check("lit_4th_out_ch0", 64'(ch(bus.DOUT, 0)), 64'd100);
    drive_cycle(1'b0, 4'b1000, 1'b0);
    check("lit_dc_removed_ch0", 64'(ch(bus.DOUT, 0)), 64'd0);
    check("lit_floor_ch1", 64'(ch(bus.DOUT, 1)), 64'd6);
`ifdef ADC_DC_SAT_EN
    check("lit_sat_ch2", 64'(ch(bus.DOUT, 2)), 64'h7fff);
`else
    check("lit_wrap_ch2", 64'(ch(bus.DOUT, 2)), 64'hffff);
`endif
    check("lit_bypass_ch3", 64'(ch(bus.DOUT, 3)), 64'd200);

    // Finish window 2, then a held window of zeros.
    repeat (3) drive_cycle(1'b1, 4'b1000, 1'b0);
    set_din(0, 0, 0, 0);
    repeat (4) drive_cycle(1'b1, 4'b1000, 1'b1);
    check("lit_hold_mean_ch3", 64'(ch(bus.MEAN_OUT, 3)), 64'd200);
    check("lit_hold_no_update", 64'(bus.MEAN_UPDATE), 64'd0);

    // Gaps: window closes on the 4th valid sample.
    set_din(40, -40, 1000, 7);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'b0000, 1'b0);
      drive_cycle(1'b0, 4'b0000, 1'b0);
      drive_cycle(1'b0, 4'b0000, 1'b0);
    end
    drive_cycle(1'b1, 4'b0000, 1'b0);
    check("lit_gap_update", 64'(bus.MEAN_UPDATE), 64'd1);
    check("lit_gap_mean_ch2", 64'(ch(bus.MEAN_OUT, 2)), 64'd1000);
    drive_cycle(1'b0, 4'b0000, 1'b0);
    drive_cycle(1'b0, 4'b0000, 1'b0);

    // Reset mid-window.
    set_din(100, 100, 100, 100);
    repeat (2) drive_cycle(1'b1, 4'b0000, 1'b0);
    do_reset();
    repeat (3) drive_cycle(1'b1, 4'b0000, 1'b0);
    check("lit_rst_no_early_update", 64'(bus.MEAN_UPDATE), 64'd0);
    drive_cycle(1'b1, 4'b0000, 1'b0);
    check("lit_rst_update", 64'(bus.MEAN_UPDATE), 64'd1);
    check("lit_rst_mean_ch0", 64'(ch(bus.MEAN_OUT, 0)), 64'd100);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++) din_v[k] = int'($urandom_range(0, 65535)) - 32768;
      drive_cycle(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0));
    end
    set_din(0, 0, 0, 0);
    repeat (3) drive_cycle(1'b0, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_dc_remover.md
# adc_dc_remover

Parametrised multi-channel DC-offset remover for the LTC2203 capture path. It sits between the per-ADC input registers, already retimed into the CLK_20M domain, and the downstream record logic. It replaces the fixed per-channel MEAN instances with one block that covers a configurable channel count and sample width. Each channel measures its mean over a block of 2^AVG_LOG2 samples and subtracts the last completed mean from subsequent samples, with per-channel bypass and a global mean-hold.

## Interface
Parameters:
- NCH, 16, number of channels
- W, 16, sample width, two's complement
- AVG_LOG2, 10, log2 of averaging window length (1..16)

Ports:
- CLK_20M  in  1  sole clock
- RESET_n  in  1  asynchronous, active-low reset
- DIN_VALID  in  1  one sample per channel present on DIN this cycle
- DIN  in  NCH*W  channel k at bits [k*W +: W]
- BYPASS  in  NCH  bit k=1: channel k passes through uncorrected
- MEAN_HOLD  in  1  1 = freeze all mean registers
- DOUT_VALID  out  1  DOUT holds corrected samples
- DOUT  out  NCH*W  corrected samples, same packing as DIN
- MEAN_OUT  out  NCH*W  current mean per channel
- MEAN_UPDATE  out  1  one-cycle pulse when the mean registers load a new value

## Operation
- Shared window counter `cnt` (AVG_LOG2 bits) advances on each DIN_VALID and wraps 2^AVG_LOG2-1 → 0.
- Per-channel accumulator, width W+AVG_LOG2, signed:
  - Valid cycle with cnt≠last: acc += din.
  - Valid cycle with cnt=last: acc ← 0 and, unless MEAN_HOLD, mean ← (acc+din) >>> AVG_LOG2. This is an arithmetic shift, so the result floors toward −∞.
- With MEAN_HOLD=1 the window still counts and accumulators still clear at wrap. The completed sum is discarded and MEAN_UPDATE stays 0.
- Pipeline stage 1, on DIN_VALID: s1_data ← din, s1_mean ← mean register value *before* this edge, s1_byp ← BYPASS[k].
- Pipeline stage 2: diff = s1_data − s1_mean, computed at W+1 bits.
  - s1_byp=1: DOUT = s1_data.
  - s1_byp=0: DOUT = diff reduced to W bits (see Configuration).
- The last sample of a window is corrected with the old mean. The first sample of the next window uses the new mean.
- Before the first completed window, mean=0, so output equals input.
- BYPASS affects only the output mux. Accumulation and mean update continue regardless of BYPASS.

## Timing
- Latency: DIN_VALID at edge n → DOUT_VALID high in the cycle after edge n+2. Fixed 2-cycle latency, no backpressure.
- Gaps in DIN_VALID are allowed. Pipeline registers hold their value, DOUT_VALID=0, and no counter advances.
- MEAN_UPDATE is high for the single cycle after the edge that loads the mean. MEAN_OUT shows the new value in that same cycle.
- BYPASS and MEAN_HOLD are sampled only on DIN_VALID cycles.
- Reset values: cnt, acc, mean, MEAN_OUT, all pipeline registers, DOUT and DOUT_VALID are all 0. MEAN_UPDATE=0.
- Reset asserted mid-window discards the partial sum and the mean. The first window after release starts at cnt=0.
- Back-to-back windows (continuous DIN_VALID) lose no samples.

## Configuration
- `ADC_DC_SAT_EN` defined: W+1-bit diff saturates to [−2^(W−1), 2^(W−1)−1].
- `ADC_DC_SAT_EN` undefined: diff keeps its low W bits (two's-complement wrap).
- Bypass path and accumulator are unaffected by the macro.

## Structure
- Shared package `adc_dc_pkg` holds:
  - the default W/AVG_LOG2 constants;
  - the saturation/truncation function `sat_w`;
  - the accumulator width constant, W+AVG_LOG2.
- Sub-module `adc_dc_chan` holds one channel's accumulator, mean register and two pipeline stages. It is instantiated NCH times by generate.
- The window counter and MEAN_UPDATE live in the top level and are shared by all channels.

## Test plan
All scenarios use NCH=4, W=16, AVG_LOG2=2.
- Constant DC: ch0 = 100 on every valid cycle.
  - First 4 outputs are 100; later outputs are 0.
  - MEAN_OUT[0]=100, and MEAN_UPDATE pulses once every 4 valid samples.
- Negative floor: ch1 inputs −1, −1, −1, 0 → mean −1 (floor of −0.75). The next input 5 → output 6.
- Saturation: ch2 window all −32768, then input 32767.
  - With ADC_DC_SAT_EN: output 32767.
  - Without ADC_DC_SAT_EN: output −1.
- Bypass and hold:
  - BYPASS[3]=1 with ch3=200: output 200 while MEAN_OUT[3] becomes 200.
  - MEAN_HOLD=1 over the next window of 0s: MEAN_OUT stays 200 and MEAN_UPDATE stays 0.
- Gaps and latency: DIN_VALID toggled 1, 0, 0, 1.
  - DOUT_VALID follows the same pattern exactly 2 cycles later.
  - The window closes on the 4th valid sample, not the 4th clock.
- Reset mid-window: RESET_n pulsed low after 2 valid samples of 100.
  - All outputs go to 0 immediately.
  - After release, a full 4 new samples are needed before MEAN_UPDATE.
